ps2_key_seq_ctrl: RTL and testbench

//  Scancode sequencer between the ps2_rx byte receiver and game logic. Consumes

---
 rtl/ps2_key_seq_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_ps2_key_seq_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_seq_ctrl.sv
// rtl/ps2_key_seq_ctrl.sv - PS/2 Set-2 scancode sequencer with direction-key held bitmap
module ps2_key_seq_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 2_000_000,
  parameter logic [7:0]  CODE_UP     = 8'h1D,
  parameter logic [7:0]  CODE_DOWN   = 8'h1B,
  parameter logic [7:0]  CODE_LEFT   = 8'h1C,
  parameter logic [7:0]  CODE_RIGHT  = 8'h23
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       rx_done_tick_i,
  input  logic [7:0] rx_data_i,
  output logic       rx_en_o,
  output logic [3:0] key_held_o,
  output logic       event_valid_o,
  output logic [7:0] event_code_o,
  output logic       event_ext_o,
  output logic       event_break_o,
  output logic       event_repeat_o,
  output logic       seq_timeout_o
);

  localparam int unsigned   TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    held_q, held_d;
  logic          rx_en_q;
  logic          ev_valid_q, ev_valid_d;
  logic [7:0]    ev_code_q, ev_code_d;
  logic          ev_ext_q, ev_ext_d;
  logic          ev_brk_q, ev_brk_d;
  logic          ev_rep_q, ev_rep_d;
  logic          tout_q, tout_d;

  logic          fire;
  logic          fire_ext;
  logic          fire_brk;
  logic [3:0]    mask;

  // Bit select {up,down,left,right} for a final code; zero when unmapped.
  function automatic logic [3:0] key_mask(input logic [7:0] code, input logic ext);
    logic [3:0] m;
    m = 4'b0000;
    if (ext) begin
      case (code)
        8'h75:   m = 4'b1000;
        8'h72:   m = 4'b0100;
        8'h6B:   m = 4'b0010;
        8'h74:   m = 4'b0001;
        default: m = 4'b0000;
      endcase
    end else begin
      if (code == CODE_UP)    m[3] = 1'b1;
      if (code == CODE_DOWN)  m[2] = 1'b1;
      if (code == CODE_LEFT)  m[1] = 1'b1;
      if (code == CODE_RIGHT) m[0] = 1'b1;
    end
    return m;
  endfunction

  // Next-state, timer and event decode; a consumed byte takes priority over timer expiry.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    held_d     = held_q;
    ev_valid_d = 1'b0;
    ev_code_d  = ev_code_q;
    ev_ext_d   = ev_ext_q;
    ev_brk_d   = ev_brk_q;
    ev_rep_d   = ev_rep_q;
    tout_d     = 1'b0;
    fire       = 1'b0;
    fire_ext   = 1'b0;
    fire_brk   = 1'b0;
    mask       = 4'b0000;

    if (!enable_i) begin
      state_d = S_IDLE;
      timer_d = '0;
      held_d  = 4'b0000;
    end else if (rx_done_tick_i) begin
      timer_d = '0;
      case (state_q)
        S_IDLE: begin
          if (rx_data_i == 8'hE0) begin
            state_d = S_EXT;
          end else if (rx_data_i == 8'hF0) begin
            state_d = S_BRK;
          end else if (!(rx_data_i inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hE1})) begin
            fire = 1'b1;
          end
        end
        S_EXT: begin
          if (rx_data_i == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else if (rx_data_i == 8'hE0) begin
            state_d = S_EXT;
          end else if (rx_data_i inside {8'h00, 8'hFF}) begin
            state_d = S_IDLE;
          end else begin
            fire     = 1'b1;
            fire_ext = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_BRK: begin
          if (rx_data_i inside {8'hE0, 8'hF0}) begin
            state_d = S_BRK;
          end else if (rx_data_i inside {8'h00, 8'hFF}) begin
            state_d = S_IDLE;
          end else begin
            fire     = 1'b1;
            fire_brk = 1'b1;
            state_d  = S_IDLE;
          end
        end
        default: begin
          if (rx_data_i inside {8'hE0, 8'hF0}) begin
            state_d = S_EXT_BRK;
          end else if (rx_data_i inside {8'h00, 8'hFF}) begin
            state_d = S_IDLE;
          end else begin
            fire     = 1'b1;
            fire_ext = 1'b1;
            fire_brk = 1'b1;
            state_d  = S_IDLE;
          end
        end
      endcase
    end else if (state_q != S_IDLE) begin
      if (timer_q == TMAX) begin
        state_d = S_IDLE;
        timer_d = '0;
        tout_d  = 1'b1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end

    if (fire) begin
      mask       = key_mask(rx_data_i, fire_ext);
      ev_valid_d = 1'b1;
      ev_code_d  = rx_data_i;
      ev_ext_d   = fire_ext;
      ev_brk_d   = fire_brk;
      ev_rep_d   = !fire_brk && ((held_q & mask) != 4'b0000);
      held_d     = fire_brk ? (held_q & ~mask) : (held_q | mask);
    end
  end

  // State, timer, bitmap and registered event outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      held_q     <= 4'b0000;
      rx_en_q    <= 1'b0;
      ev_valid_q <= 1'b0;
      ev_code_q  <= 8'h00;
      ev_ext_q   <= 1'b0;
      ev_brk_q   <= 1'b0;
      ev_rep_q   <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      held_q     <= held_d;
      rx_en_q    <= enable_i;
      ev_valid_q <= ev_valid_d;
      ev_code_q  <= ev_code_d;
      ev_ext_q   <= ev_ext_d;
      ev_brk_q   <= ev_brk_d;
      ev_rep_q   <= ev_rep_d;
      tout_q     <= tout_d;
    end
  end

  assign rx_en_o        = rx_en_q;
  assign key_held_o     = held_q;
  assign event_valid_o  = ev_valid_q;
  assign event_code_o   = ev_code_q;
  assign event_ext_o    = ev_ext_q;
  assign event_break_o  = ev_brk_q;
  assign event_repeat_o = ev_rep_q;
  assign seq_timeout_o  = tout_q;

endmodule

// File: tb/tb_ps2_key_seq_ctrl.sv
// tb/tb_ps2_key_seq_ctrl.sv - scoreboard bench for the PS/2 scancode sequencer
module tb_ps2_key_seq_ctrl;

  localparam int T = 20;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] data = 8'h00;
  logic       rx_en;
  logic [3:0] key_held;
  logic       event_valid;
  logic [7:0] event_code;
  logic       event_ext;
  logic       event_break;
  logic       event_repeat;
  logic       seq_timeout;

  int  errors = 0;
  int  checks = 0;
  int  tout_cnt = 0;
  ev_t exp_q[$];
  ev_t mon_e;

  ps2_key_seq_ctrl #(.TIMEOUT_CYC(T)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (enable),
    .rx_done_tick_i (tick),
    .rx_data_i      (data),
    .rx_en_o        (rx_en),
    .key_held_o     (key_held),
    .event_valid_o  (event_valid),
    .event_code_o   (event_code),
    .event_ext_o    (event_ext),
    .event_break_o  (event_break),
    .event_repeat_o (event_repeat),
    .seq_timeout_o  (seq_timeout)
  );

  always #5 clk = ~clk;

  // Scoreboard: every event pulse is matched against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (rst_n && seq_timeout) tout_cnt++;
    if (rst_n && event_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got code=%h ext=%b brk=%b rep=%b, expected none",
                 event_code, event_ext, event_break, event_repeat);
      end else begin
        mon_e = exp_q.pop_front();
        if ({event_code, event_ext, event_break, event_repeat} !== mon_e) begin
          errors++;
          $display("FAIL event_fields: got code=%h ext=%b brk=%b rep=%b, expected code=%h ext=%b brk=%b rep=%b",
                   event_code, event_ext, event_break, event_repeat,
                   mon_e.code, mon_e.ext, mon_e.brk, mon_e.rep);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    tick = 1'b1;
    data = b;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic push(input logic [7:0] c, input logic e, input logic br, input logic r);
    ev_t x;
    x.code = c;
    x.ext  = e;
    x.brk  = br;
    x.rep  = r;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    enable = 1'b1;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rx_en, key_held, event_valid, event_code, event_ext, event_break, event_repeat, seq_timeout} !== 18'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rx_en=%b held=%b ev=%b code=%h tout=%b, expected all 0",
               rx_en, key_held, event_valid, event_code, seq_timeout);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_en !== 1'b1) begin
      errors++;
      $display("FAIL rx_en_after_reset: got %b expected 1", rx_en);
    end
    send(8'hE0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_en, key_held, event_valid, event_code, event_ext, event_break, event_repeat, seq_timeout} !== 18'h0) begin
      errors++;
      $display("FAIL reset_mid_seq: got rx_en=%b held=%b ev=%b code=%h, expected all 0",
               rx_en, key_held, event_valid, event_code);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(8'h1D, 1'b0, 1'b0, 1'b0);
    send(8'h1D);
    checks++;
    if (event_valid !== 1'b1 || key_held !== 4'b1000) begin
      errors++;
      $display("FAIL reset_first_make: got ev=%b held=%b expected ev=1 held=1000", event_valid, key_held);
    end
  endtask

  task automatic test_make_break();
    do_reset();
    push(8'h1D, 1'b0, 1'b0, 1'b0);
    send(8'h1D);
    checks++;
    if (event_valid !== 1'b1 || key_held !== 4'b1000) begin
      errors++;
      $display("FAIL make_up: got ev=%b held=%b expected ev=1 held=1000", event_valid, key_held);
    end
    send(8'hF0);
    checks++;
    if (event_valid !== 1'b0 || key_held !== 4'b1000) begin
      errors++;
      $display("FAIL break_prefix: got ev=%b held=%b expected ev=0 held=1000", event_valid, key_held);
    end
    push(8'h1D, 1'b0, 1'b1, 1'b0);
    send(8'h1D);
    checks++;
    if (event_valid !== 1'b1 || key_held !== 4'b0000) begin
      errors++;
      $display("FAIL break_up: got ev=%b held=%b expected ev=1 held=0000", event_valid, key_held);
    end
    @(negedge clk);
    checks++;
    if (event_valid !== 1'b0 || event_code !== 8'h1D || event_break !== 1'b1) begin
      errors++;
      $display("FAIL event_hold: got ev=%b code=%h brk=%b expected ev=0 code=1d brk=1",
               event_valid, event_code, event_break);
    end
  endtask

  task automatic test_two_keys();
    do_reset();
    push(8'h6B, 1'b1, 1'b0, 1'b0);
    send(8'hE0);
    send(8'h6B);
    checks++;
    if (key_held !== 4'b0010) begin
      errors++;
      $display("FAIL ext_left: got held=%b expected 0010", key_held);
    end
    push(8'h1B, 1'b0, 1'b0, 1'b0);
    send(8'h1B);
    checks++;
    if (key_held !== 4'b0110) begin
      errors++;
      $display("FAIL down_plus_left: got held=%b expected 0110", key_held);
    end
    push(8'h1B, 1'b0, 1'b0, 1'b1);
    send(8'h1B);
    checks++;
    if (key_held !== 4'b0110 || event_repeat !== 1'b1) begin
      errors++;
      $display("FAIL typematic: got held=%b rep=%b expected held=0110 rep=1", key_held, event_repeat);
    end
  endtask

  task automatic test_ext_break();
    push(8'h23, 1'b0, 1'b0, 1'b0);
    send(8'h23);
    checks++;
    if (key_held !== 4'b0111) begin
      errors++;
      $display("FAIL right_make: got held=%b expected 0111", key_held);
    end
    send(8'hE0);
    send(8'hF0);
    checks++;
    if (event_valid !== 1'b0) begin
      errors++;
      $display("FAIL ext_brk_prefix: got ev=%b expected 0", event_valid);
    end
    push(8'h74, 1'b1, 1'b1, 1'b0);
    send(8'h74);
    checks++;
    if (event_valid !== 1'b1 || key_held !== 4'b0110) begin
      errors++;
      $display("FAIL ext_break_right: got ev=%b held=%b expected ev=1 held=0110", event_valid, key_held);
    end
  endtask

  task automatic test_timeout();
    int bad;
    int t0;
    do_reset();
    send(8'hE0);
    t0  = tout_cnt;
    bad = 0;
    for (int k = 1; k <= T + 4; k++) begin
      @(negedge clk);
      if (seq_timeout !== (k == T)) bad++;
    end
    checks++;
    if (bad != 0 || tout_cnt - t0 != 1) begin
      errors++;
      $display("FAIL timeout_pulse: got %0d bad cycles and %0d pulses, expected 0 bad and 1 pulse",
               bad, tout_cnt - t0);
    end
    push(8'h23, 1'b0, 1'b0, 1'b0);
    send(8'h23);
    checks++;
    if (event_valid !== 1'b1 || key_held !== 4'b0001) begin
      errors++;
      $display("FAIL after_timeout_make: got ev=%b held=%b expected ev=1 held=0001", event_valid, key_held);
    end
    send(8'hE0);
    t0 = tout_cnt;
    repeat (T - 1) @(negedge clk);
    push(8'h1C, 1'b1, 1'b0, 1'b0);
    send(8'h1C);
    checks++;
    if (event_valid !== 1'b1 || seq_timeout !== 1'b0 || key_held !== 4'b0001) begin
      errors++;
      $display("FAIL byte_on_expiry: got ev=%b tout=%b held=%b expected ev=1 tout=0 held=0001",
               event_valid, seq_timeout, key_held);
    end
    repeat (T + 2) @(negedge clk);
    checks++;
    if (tout_cnt != t0) begin
      errors++;
      $display("FAIL no_timeout_after_byte: got %0d pulses expected 0", tout_cnt - t0);
    end
  endtask

  task automatic test_enable();
    do_reset();
    push(8'h1C, 1'b0, 1'b0, 1'b0);
    send(8'h1C);
    checks++;
    if (key_held !== 4'b0010) begin
      errors++;
      $display("FAIL hold_left: got held=%b expected 0010", key_held);
    end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_en !== 1'b0 || key_held !== 4'b0000) begin
      errors++;
      $display("FAIL disable_flush: got rx_en=%b held=%b expected rx_en=0 held=0000", rx_en, key_held);
    end
    send(8'h1D);
    @(negedge clk);
    checks++;
    if (event_valid !== 1'b0 || key_held !== 4'b0000 || rx_en !== 1'b0) begin
      errors++;
      $display("FAIL disabled_drop: got ev=%b held=%b rx_en=%b expected 0 0000 0",
               event_valid, key_held, rx_en);
    end
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_en !== 1'b1) begin
      errors++;
      $display("FAIL reenable: got rx_en=%b expected 1", rx_en);
    end
    send(8'hF0);
    send(8'h00);
    checks++;
    if (event_valid !== 1'b0 || seq_timeout !== 1'b0) begin
      errors++;
      $display("FAIL abort_brk: got ev=%b tout=%b expected 0 0", event_valid, seq_timeout);
    end
    push(8'h1D, 1'b0, 1'b0, 1'b0);
    send(8'h1D);
    checks++;
    if (event_valid !== 1'b1 || key_held !== 4'b1000) begin
      errors++;
      $display("FAIL make_after_abort: got ev=%b held=%b expected ev=1 held=1000", event_valid, key_held);
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_make_break();
    test_two_keys();
    test_ext_break();
    test_timeout();
    test_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
